// File: rtl/instruction_fetch.sv
// Program counter and fetch stage for a 6-bit-addressed combinational instruction memory.
// Optional halt-on-zero-word behaviour is enabled with the macro FETCH_HALT_ON_ZERO_EN.
module instruction_fetch #(
    parameter int ADDR_W               = 6,
    parameter int INSTR_W              = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  PCAdress,
    input  logic [INSTR_W-1:0] Instruction_in,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_nxt_s;
    logic [INSTR_W-1:0] ir_out_r;
    logic [INSTR_W-1:0] ir_out_nxt_s;
    logic [ADDR_W-1:0]  ir_pc_r;
    logic [ADDR_W-1:0]  ir_pc_nxt_s;
    logic               ir_valid_r;
    logic               ir_valid_nxt_s;
    logic               halted_r;
    logic               halted_nxt_s;
    logic               advance_s;
    logic               load_s;

    // Decide whether the fetch stage may move forward this cycle.
    always_comb begin
        advance_s = 1'b0;
        case (state_r)
            ST_RUN:  advance_s = !ir_valid_r || ir_ready;
            ST_HALT: advance_s = 1'b0;
            default: advance_s = 1'b0;
        endcase
    end

    // Decide whether an advance actually captures the memory word.
    always_comb begin
        load_s = 1'b0;
`ifdef FETCH_HALT_ON_ZERO_EN
        if (advance_s && (Instruction_in != {INSTR_W{1'b0}})) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
`else
        if (advance_s) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
`endif
    end

    // Next-state logic: redirect beats advance, advance beats hold.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        ir_out_nxt_s   = ir_out_r;
        ir_pc_nxt_s    = ir_pc_r;
        ir_valid_nxt_s = ir_valid_r;
        halted_nxt_s   = halted_r;
        if (redirect_valid) begin
            // Flush: a word handed over on this same edge is already taken by decode.
            pc_nxt_s       = redirect_pc;
            ir_valid_nxt_s = 1'b0;
            state_nxt_s    = ST_RUN;
            halted_nxt_s   = 1'b0;
        end else if (load_s) begin
            ir_out_nxt_s   = Instruction_in;
            ir_pc_nxt_s    = pc_r;
            ir_valid_nxt_s = 1'b1;
            pc_nxt_s       = pc_r + ADDR_W'(1);
        end else if (advance_s) begin
            // Zero word fetched with halt enabled: stop without consuming it.
            ir_valid_nxt_s = 1'b0;
            state_nxt_s    = ST_HALT;
            halted_nxt_s   = 1'b1;
        end else if (ir_valid_r && ir_ready) begin
            ir_valid_nxt_s = 1'b0;
        end else begin
            ir_valid_nxt_s = ir_valid_r;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            ir_out_r   <= {INSTR_W{1'b0}};
            ir_pc_r    <= {ADDR_W{1'b0}};
            ir_valid_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            ir_out_r   <= ir_out_nxt_s;
            ir_pc_r    <= ir_pc_nxt_s;
            ir_valid_r <= ir_valid_nxt_s;
            halted_r   <= halted_nxt_s;
        end
    end

    assign PCAdress = pc_r;
    assign ir_out   = ir_out_r;
    assign ir_pc    = ir_pc_r;
    assign ir_valid = ir_valid_r;
    assign halted   = halted_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed table-driven bench for instruction_fetch with a small instruction memory model.
module tb_instruction_fetch;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 32;

    logic               clk;
    logic               rst_n;
    logic [ADDR_W-1:0]  PCAdress;
    logic [INSTR_W-1:0] Instruction_in;
    logic [INSTR_W-1:0] ir_out;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_valid;
    logic               ir_ready;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halted;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic               ready;
        logic               redir;
        logic [ADDR_W-1:0]  rpc;
        logic               exp_valid;
        logic [INSTR_W-1:0] exp_ir;
        logic [ADDR_W-1:0]  exp_irpc;
        logic [ADDR_W-1:0]  exp_pc;
        logic               exp_halted;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(6'd0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PCAdress       (PCAdress),
        .Instruction_in (Instruction_in),
        .ir_out         (ir_out),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (PCAdress)
            6'd0:    Instruction_in = 32'h0040_0005;
            6'd1:    Instruction_in = 32'h00C0_0002;
            6'd2:    Instruction_in = 32'h1064_0046;
            default: Instruction_in = 32'h0000_0000;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic rv, input logic [ADDR_W-1:0] rp,
                       input logic ev, input logic [INSTR_W-1:0] ei,
                       input logic [ADDR_W-1:0] eip, input logic [ADDR_W-1:0] epc,
                       input logic eh);
        vec_t v;
        v.ready = rd; v.redir = rv; v.rpc = rp;
        v.exp_valid = ev; v.exp_ir = ei; v.exp_irpc = eip; v.exp_pc = epc; v.exp_halted = eh;
        vecs.push_back(v);
    endtask

    initial begin
        // stream, stall, release, redirect
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h0040_0005, 6'd0, 6'd1, 1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h00C0_0002, 6'd1, 6'd2, 1'b0);
        add(1'b0, 1'b0, 6'd0,  1'b1, 32'h00C0_0002, 6'd1, 6'd2, 1'b0);
        add(1'b0, 1'b0, 6'd0,  1'b1, 32'h00C0_0002, 6'd1, 6'd2, 1'b0);
        add(1'b0, 1'b0, 6'd0,  1'b1, 32'h00C0_0002, 6'd1, 6'd2, 1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h1064_0046, 6'd2, 6'd3, 1'b0);
        add(1'b1, 1'b1, 6'd1,  1'b0, 32'h1064_0046, 6'd2, 6'd1, 1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h00C0_0002, 6'd1, 6'd2, 1'b0);
`ifdef FETCH_HALT_ON_ZERO_EN
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h1064_0046, 6'd2, 6'd3, 1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b0, 32'h1064_0046, 6'd2, 6'd3, 1'b1);
        add(1'b1, 1'b0, 6'd0,  1'b0, 32'h1064_0046, 6'd2, 6'd3, 1'b1);
        add(1'b1, 1'b1, 6'd0,  1'b0, 32'h1064_0046, 6'd2, 6'd0, 1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h0040_0005, 6'd0, 6'd1, 1'b0);
`else
        // wrap 63 -> 0, then zero words forwarded as ordinary instructions
        add(1'b1, 1'b1, 6'd63, 1'b0, 32'h00C0_0002, 6'd1,  6'd63, 1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h0000_0000, 6'd63, 6'd0,  1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h0040_0005, 6'd0,  6'd1,  1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h00C0_0002, 6'd1,  6'd2,  1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h1064_0046, 6'd2,  6'd3,  1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h0000_0000, 6'd3,  6'd4,  1'b0);
        add(1'b1, 1'b0, 6'd0,  1'b1, 32'h0000_0000, 6'd4,  6'd5,  1'b0);
`endif

        rst_n          = 1'b0;
        ir_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 6'd0;
        #12;
        chk("reset_valid",  {31'd0, ir_valid}, 32'd0);
        chk("reset_pc",     {26'd0, PCAdress}, 32'd0);
        chk("reset_ir",     ir_out, 32'd0);
        chk("reset_irpc",   {26'd0, ir_pc}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            ir_ready       = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
            chk($sformatf("row%0d_valid", i),  {31'd0, ir_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("row%0d_ir", i),     ir_out, vecs[i].exp_ir);
            chk($sformatf("row%0d_irpc", i),   {26'd0, ir_pc}, {26'd0, vecs[i].exp_irpc});
            chk($sformatf("row%0d_pc", i),     {26'd0, PCAdress}, {26'd0, vecs[i].exp_pc});
            chk($sformatf("row%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
        end

        // restart from 0 and stall on the second word, then reset asynchronously mid-stall
        ir_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 6'd0;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ir_ready = 1'b0;
        @(posedge clk); #1;
        chk("stall_ir",    ir_out, 32'h00C0_0002);
        chk("stall_pc",    {26'd0, PCAdress}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, ir_valid}, 32'd0);
        chk("async_pc",    {26'd0, PCAdress}, 32'd0);
        chk("async_ir",    ir_out, 32'd0);
        @(negedge clk);
        ir_ready = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ir",   ir_out, 32'h0040_0005);
        chk("post_reset_irpc", {26'd0, ir_pc}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
